// File: rtl/lstm_pkg.sv
// lstm_pkg: shared constants and elaboration helpers for the LSTM forward sequencer.
// Holds the FSM state encoding, the neuron-window length helper and the
// address-width checks used at elaboration time.
package lstm_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Neuron window length WIN: NUM_CELL operand cycles plus the MAC drain
  function automatic int unsigned win_of(input int unsigned num_cell,
                                         input int unsigned delay);
    return num_cell + delay;
  endfunction

  // True when 'value' is representable in 'addr_width' unsigned bits
  function automatic bit value_fits(input int unsigned addr_width,
                                    input longint unsigned value);
    if (addr_width >= 64) return 1'b1;
    return value < (64'd1 << addr_width);
  endfunction

  // Highest h/c write address is NUM_CELL*(TIMESTEP+1)-1 (slot 0 row is t=-1)
  function automatic bit addr_fits(input int unsigned addr_width,
                                   input int unsigned num_cell,
                                   input int unsigned timestep);
    longint unsigned top_addr;
    top_addr = 64'(num_cell) * (64'(timestep) + 64'd1) - 64'd1;
    return value_fits(addr_width, top_addr);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-(MAX+1) up-counter with synchronous clear and a wrap
// strobe for chaining. Ports: clk, rst_n (async active-low), i_clr, i_en,
// o_nxt (value the counter takes at the next edge), o_wrap (en while at MAX).
module wrap_counter
  import lstm_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == MAX_V);
  // Wrap is qualified by enable so the next counter in the chain steps once
  assign o_wrap   = i_en && w_at_max;

  // Next value is exported so the owner can register outputs in step with it
  always_comb begin
    o_nxt = r_cnt;
    if (i_clr) begin
      o_nxt = '0;
    end else if (i_en) begin
      o_nxt = w_at_max ? '0 : r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_nxt;
    end
  end

endmodule

// File: rtl/lstm_fwd_ctrl.sv
// lstm_fwd_ctrl: forward-propagation sequencer for one LSTM layer; walks
// TIMESTEP x NUM_CELL neuron windows of WIN cycles from one start pulse.
// Ports: clk, rst (async active-low), start, i_hold in; o_busy, o_done,
// o_en_addr, o_acc_clr, o_wr_en, o_wr_addr, o_t out (all registered).
module lstm_fwd_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TIMESTEP   = 7,
  parameter int unsigned NUM_CELL   = 53,
  parameter int unsigned DELAY      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  i_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_en_addr,
  output logic                  o_acc_clr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_t
);

  localparam int unsigned WIN = win_of(NUM_CELL, DELAY);
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(WIN - 1);
  localparam logic [ADDR_WIDTH-1:0] NC_A   = ADDR_WIDTH'(NUM_CELL);

  generate
    if (!addr_fits(ADDR_WIDTH, NUM_CELL, TIMESTEP) ||
        !value_fits(ADDR_WIDTH, 64'(WIN - 1))) begin : g_addr_chk
      $error("lstm_fwd_ctrl: ADDR_WIDTH too small for NUM_CELL/TIMESTEP/DELAY");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic [ADDR_WIDTH-1:0] w_k_nxt;
  logic [ADDR_WIDTH-1:0] w_n_nxt;
  logic [ADDR_WIDTH-1:0] w_t_nxt;
  logic                  w_go;
  logic                  w_run;
  logic                  w_adv;
  logic                  w_k_wrap;
  logic                  w_n_wrap;
  logic                  w_t_wrap;
  logic                  w_issue;

  assign w_go  = (r_state == ST_IDLE) && start;
  assign w_run = (r_state == ST_RUN);
  // A held cycle neither advances the counters nor issues a window position
  assign w_adv = w_run && !i_hold;

  wrap_counter #(.WIDTH(ADDR_WIDTH), .MAX(WIN - 1)) u_k_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (w_go),
    .i_en   (w_adv),
    .o_nxt  (w_k_nxt),
    .o_wrap (w_k_wrap)
  );

  wrap_counter #(.WIDTH(ADDR_WIDTH), .MAX(NUM_CELL - 1)) u_n_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (w_go),
    .i_en   (w_k_wrap),
    .o_nxt  (w_n_nxt),
    .o_wrap (w_n_wrap)
  );

  wrap_counter #(.WIDTH(ADDR_WIDTH), .MAX(TIMESTEP - 1)) u_t_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (w_go),
    .i_en   (w_n_wrap),
    .o_nxt  (w_t_nxt),
    .o_wrap (w_t_wrap)
  );

  // The whole chain wrapping means the final window position was just retired
  assign w_issue = w_go || (w_adv && !w_t_wrap);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)    w_state_nxt = ST_RUN;
      ST_RUN:  if (w_t_wrap) w_state_nxt = ST_DONE;
      ST_DONE:               w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Running row base NUM_CELL*(t+1): bumps by NUM_CELL on each timestep step
  always_comb begin
    w_base_nxt = r_base;
    if (w_go) begin
      w_base_nxt = NC_A;
    end else if (w_n_wrap) begin
      w_base_nxt = w_t_wrap ? NC_A : r_base + NC_A;
    end
  end

  // Outputs are registered from the next counter values so they line up with
  // the counter position they describe; i_hold is seen one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_en_addr <= 1'b0;
      o_acc_clr <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_t       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      o_busy    <= (w_state_nxt == ST_RUN);
      o_done    <= (w_state_nxt == ST_DONE);
      o_en_addr <= w_issue;
      o_acc_clr <= w_issue && (w_k_nxt == '0);
      o_wr_en   <= w_issue && (w_k_nxt == K_LAST);
      if (w_issue) begin
        o_wr_addr <= w_base_nxt + w_n_nxt;
        o_t       <= w_t_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lstm_fwd_ctrl.sv
module tb_lstm_fwd_ctrl;

  localparam int AW   = 12;
  localparam int TS   = 2;
  localparam int NC   = 3;
  localparam int DL   = 2;
  localparam int WIN  = NC + DL;
  localparam int NPOS = TS * NC * WIN;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          en;
    logic          clr;
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] t;
  } out_t;

  typedef struct packed {
    logic start;
    logic hold;
    out_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          busy, done, en, clr, wr;
  logic [AW-1:0] waddr, tt;

  logic          start_d = 1'b0;
  logic          hold_d = 1'b0;
  logic          busy_d, done_d, en_d, clr_d, wr_d;
  logic [11:0]   waddr_d, tt_d;

  always #5 clk = ~clk;

  lstm_fwd_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(TS), .NUM_CELL(NC), .DELAY(DL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .i_hold(hold),
    .o_busy(busy), .o_done(done), .o_en_addr(en), .o_acc_clr(clr),
    .o_wr_en(wr), .o_wr_addr(waddr), .o_t(tt)
  );

  lstm_fwd_ctrl u_def (
    .clk(clk), .rst(rst), .start(start_d), .i_hold(hold_d),
    .o_busy(busy_d), .o_done(done_d), .o_en_addr(en_d), .o_acc_clr(clr_d),
    .o_wr_en(wr_d), .o_wr_addr(waddr_d), .o_t(tt_d)
  );

  int   n_pass = 0;
  int   n_chk  = 0;
  vec_t vecs[$];
  out_t sb[$];
  int   wr_cyc[$];
  int   wr_adr[$];
  int   clr_cyc[$];
  int   busy_n, done_n, done_cyc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic out_t sample();
    out_t o;
    o.busy = busy; o.done = done; o.en = en; o.clr = clr; o.wr = wr;
    o.addr = waddr; o.t = tt;
    return o;
  endfunction

  // Expected outputs for window position p of an un-stalled run
  function automatic out_t pos_out(input int p);
    out_t o;
    int k, n, t;
    k = p % WIN;
    n = (p / WIN) % NC;
    t = p / (WIN * NC);
    o.busy = 1'b1; o.done = 1'b0; o.en = 1'b1;
    o.clr  = (k == 0);
    o.wr   = (k == WIN - 1);
    o.addr = AW'(NC * (t + 1) + n);
    o.t    = AW'(t);
    return o;
  endfunction

  // Vector table: record i holds the inputs sampled at edge i and the
  // outputs expected right after it. Hold records are inserted before
  // position hold_at; spam drives start on every record after the first.
  task automatic build(input int hold_at, input int hold_len, input bit spam);
    vec_t v;
    out_t o;
    vecs.delete();
    for (int p = 0; p < NPOS; p++) begin
      if (p == hold_at) begin
        for (int h = 0; h < hold_len; h++) begin
          o = pos_out(p - 1);
          o.en = 1'b0; o.clr = 1'b0; o.wr = 1'b0;
          v.start = spam; v.hold = 1'b1; v.exp = o;
          vecs.push_back(v);
        end
      end
      v.start = (p == 0) ? 1'b1 : spam;
      v.hold  = 1'b0;
      v.exp   = pos_out(p);
      vecs.push_back(v);
    end
    o = '0;
    o.done = 1'b1;
    o.addr = AW'(NC * TS + NC - 1);
    o.t    = AW'(TS - 1);
    v.start = spam; v.hold = 1'b0; v.exp = o;
    vecs.push_back(v);
    o.done = 1'b0;
    v.exp = o;
    vecs.push_back(v);
    v.start = 1'b0;
    vecs.push_back(v);
    vecs.push_back(v);
  endtask

  task automatic apply(input string tag, input int nrec);
    out_t got, e;
    wr_cyc.delete(); wr_adr.delete(); clr_cyc.delete();
    busy_n = 0; done_n = 0; done_cyc = -1;
    for (int i = 0; i < nrec; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      hold  = vecs[i].hold;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got = sample();
      e = sb.pop_front();
      chk($sformatf("%s[%0d]", tag, i), 64'(got), 64'(e));
      if (got.wr) begin wr_cyc.push_back(i + 1); wr_adr.push_back(int'(got.addr)); end
      if (got.clr) clr_cyc.push_back(i + 1);
      if (got.busy) busy_n++;
      if (got.done) begin done_n++; done_cyc = i + 1; end
    end
  endtask

  int exp_wr[6] = '{3, 4, 5, 6, 7, 8};

  initial begin
    bit seen;
    int b, nw, nd, first_a, last_a;

    #3;
    chk("reset_state", 64'(sample()), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic run
    build(-1, 0, 1'b0);
    apply("basic", vecs.size());
    chk("basic_busy_cycles", 64'(busy_n), 64'd30);
    chk("basic_done_count", 64'(done_n), 64'd1);
    chk("basic_done_cycle", 64'(done_cyc), 64'd31);
    chk("basic_wr_count", 64'(wr_adr.size()), 64'd6);
    for (int i = 0; i < 6 && i < wr_adr.size(); i++)
      chk($sformatf("basic_wr_addr%0d", i), 64'(wr_adr[i]), 64'(exp_wr[i]));
    chk("basic_clr_count", 64'(clr_cyc.size()), 64'd6);
    for (int i = 1; i < clr_cyc.size(); i++)
      chk($sformatf("basic_clr_gap%0d", i), 64'(clr_cyc[i] - clr_cyc[i-1]), 64'd5);

    // Hold for 4 cycles at k=2 of neuron 1
    build(7, 4, 1'b0);
    apply("hold", vecs.size());
    chk("hold_busy_cycles", 64'(busy_n), 64'd34);
    chk("hold_wr4_cycle", 64'(wr_cyc.size() > 1 ? wr_cyc[1] : -1), 64'd14);
    chk("hold_done_count", 64'(done_n), 64'd1);

    // Reset mid-run
    build(-1, 0, 1'b0);
    apply("rst_pre", 12);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async_outputs", 64'(sample()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("rst_idle[%0d]", i), 64'(sample()), 64'd0);
    end
    apply("post_rst", vecs.size());
    chk("post_rst_busy", 64'(busy_n), 64'd30);

    // Start pulsed throughout RUN and in the DONE cycle
    build(-1, 0, 1'b1);
    apply("ign_start", vecs.size());
    chk("ign_start_busy", 64'(busy_n), 64'd30);
    chk("ign_start_done", 64'(done_n), 64'd1);

    // Hold on the final window cycle for 3 cycles
    build(NPOS - 1, 3, 1'b0);
    apply("bnd_hold", vecs.size());
    chk("bnd_wr8_cycle", 64'(wr_cyc.size() == 6 ? wr_cyc[5] : -1), 64'd33);
    chk("bnd_done_cycle", 64'(done_cyc), 64'd34);
    chk("bnd_done_count", 64'(done_n), 64'd1);

    // Default parameters
    seen = 1'b0; b = 0; nw = 0; nd = 0; first_a = -1; last_a = -1;
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      if (busy_d) b++;
      if (wr_d) begin
        if (nw == 0) first_a = int'(waddr_d);
        last_a = int'(waddr_d);
        nw++;
      end
      if (done_d) begin nd++; seen = 1'b1; end
      if (seen) break;
      @(negedge clk);
    end
    chk("def_done_seen", 64'(seen), 64'd1);
    chk("def_run_cycles", 64'(b), 64'd21518);
    chk("def_wr_count", 64'(nw), 64'd371);
    chk("def_first_addr", 64'(first_a), 64'd53);
    chk("def_last_addr", 64'(last_a), 64'd423);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_d) nd++;
    end
    chk("def_done_single", 64'(nd), 64'd1);
    chk("def_t_final", 64'(tt_d), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lstm_fwd_ctrl.md
# lstm_fwd_ctrl

Forward-propagation sequencer for one LSTM layer. It frames every neuron's dot-product window for the H/C read-address generator and the MAC datapath: address-generator enable, accumulator clear, and write strobe/address for the new h/c value. It walks TIMESTEP × NUM_CELL neuron windows from a single `start` pulse, then pulses `o_done`. It sits between the layer-level top controller and the address-generator/MAC/H-C-memory cluster.

## Interface
- ADDR_WIDTH, 12, width of memory address and all internal counters
- TIMESTEP, 7, number of timesteps processed per run
- NUM_CELL, 53, cells per layer; also the MAC length per neuron
- DELAY, 5, MAC pipeline latency in cycles (gap between last operand read and result valid)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  run request, sampled only in IDLE
- i_hold  input  1  stall from memory/top; freezes sequencing while high
- o_busy  output  1  high from the cycle after accepted start through the last RUN cycle
- o_done  output  1  one-cycle pulse after the final write
- o_en_addr  output  1  enable to the H/C read-address generator
- o_acc_clr  output  1  clear MAC accumulator; high on the first cycle of each neuron window
- o_wr_en  output  1  write strobe for the new h/c value
- o_wr_addr  output  ADDR_WIDTH  h/c write address
- o_t  output  ADDR_WIDTH  current timestep index, 0..TIMESTEP-1

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: `start`=1 moves to RUN and clears the `k`, `n` and `t` counters. `start` is ignored in RUN and DONE.
- RUN counters:
  - `k` is the position in the neuron window, 0..WIN-1, where WIN = NUM_CELL+DELAY.
  - `n` is the neuron index, 0..NUM_CELL-1.
  - `t` is the timestep, 0..TIMESTEP-1.
  - `k` wraps to 0 and increments `n`. `n` wraps to 0 and increments `t`.
- Output behaviour in RUN, with `i_hold`=0:
  - `o_en_addr`=1 on every cycle.
  - `o_acc_clr`=1 when k=0.
  - `o_wr_en`=1 when k=WIN-1.
  - `o_wr_addr` = NUM_CELL*(t+1)+n. Slot 0..NUM_CELL-1 is reserved for the t=-1 zeros and is never written.
- Final window: on the cycle where k=WIN-1, n=NUM_CELL-1 and t=TIMESTEP-1, the FSM moves to DONE. In DONE, `o_done`=1 and `o_busy`=0 for exactly one cycle, then the FSM returns to IDLE.
- `i_hold`=1 in RUN:
  - Counters and state are frozen.
  - `o_en_addr`, `o_acc_clr` and `o_wr_en` are forced to 0.
  - `o_wr_addr` and `o_t` hold their values.
  - The cycle after hold drops, sequencing resumes at the frozen `k`. No strobe is lost or duplicated.
- Arithmetic: `o_wr_addr` is computed as a running base (+NUM_CELL per timestep) plus `n`. No multiplier is used. The maximum value is NUM_CELL*(TIMESTEP+1)-1 and must fit in ADDR_WIDTH; the parameter check is an elaboration-time assertion.

## Timing
- Reset (rst=0, asynchronous) drives all outputs and counters to 0 and the state to IDLE. This applies mid-run as well: no done pulse and no write follow.
- Latency from `start` high (IDLE) to the first `o_en_addr`/`o_acc_clr`/`o_busy` high: 1 cycle.
- Un-stalled run length is TIMESTEP*NUM_CELL*WIN RUN cycles. With the defaults this is 7*53*58 = 21518 cycles, followed by 1 DONE cycle.
- Write strobe timing: `o_wr_en` is high on the same cycle as the k=WIN-1 update, DELAY cycles after the last operand cycle (k=NUM_CELL-1).
- Simultaneous events:
  - `i_hold`=1 on the final cycle postpones the DONE transition.
  - `start` high in the DONE cycle is ignored. A new run needs `start` high while in IDLE.

## Structure
- Shared package `lstm_pkg` holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the derived constant WIN
  - the address-width check function
- One natural sub-module, `wrap_counter` (parameters WIDTH, MAX; ports en, wrap output). It is instantiated three times and chained for `k`, `n` and `t`.
- Target size is about 150–250 lines of RTL.

## Test plan
All scenarios use TIMESTEP=2, NUM_CELL=3, DELAY=2 (WIN=5) unless stated otherwise.
- Basic run: `start` pulse in IDLE.
  - `o_busy` is high for 30 cycles.
  - `o_acc_clr` pulses 6 times, 5 cycles apart.
  - `o_wr_en` pulses 6 times with `o_wr_addr` = 3,4,5,6,7,8.
  - `o_t` steps 0→1 after the third write.
  - `o_done` is a single pulse on cycle 31.
- Hold: assert `i_hold` for 4 cycles starting at k=2 of neuron 1.
  - All strobes are low during the hold; `o_wr_addr` holds.
  - The write for address 4 arrives exactly 4 cycles later than in the basic run.
  - The total run is 34 cycles.
- Reset mid-run: pull `rst` low at run cycle 12 for 1 cycle.
  - All outputs go to 0 immediately.
  - The FSM is in IDLE; no `o_done` appears.
  - A following `start` reproduces the basic-run sequence exactly.
- Ignored start: pulse `start` repeatedly during RUN and in the DONE cycle.
  - The sequence is identical to the basic run.
  - No second run begins.
- Boundary hold: hold on the final cycle (k=4, n=2, t=1) for 3 cycles.
  - The write to address 8 and the DONE transition are both delayed 3 cycles.
  - `o_done` remains a single pulse.
- Default parameters: one run takes 21518 RUN cycles. The last write address is 423 and the first is 53.
